// File: rtl/pixel_stream_fb_writer.sv
// Packetised pixel-stream sink: packs 30-bit RGB beats to RGB444 and writes a frame buffer.
// Optional statistics counters enabled by defining PIXEL_FB_STATS_EN.
`default_nettype none

module pixel_stream_fb_writer #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240,
  parameter int DATA_W   = 30,
  parameter int ADDR_W   = 17,
  parameter int PIX_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sop,
  input  logic              s_eop,
  input  logic              hold,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_en,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
`ifdef PIXEL_FB_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       err_count
`endif
);

  localparam int COL_W = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int ROW_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int CH_W  = DATA_W / 3;
  localparam int PK_W  = PIX_W / 3;

  localparam logic [1:0] WAIT_SOP = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] FLUSH    = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [COL_W-1:0] col, col_nxt, pos_col;
  logic [ROW_W-1:0] row, row_nxt, pos_row;
  logic             accept, sop_entry, pix_write, at_last;
  logic             done_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [PIX_W-1:0]  data_nxt;
  logic             unused_data;

  assign unused_data = ^s_data;

  // A startofpacket beat always lands at pixel (0,0), whatever state we are in.
  always_comb begin
    accept    = s_valid & s_ready;
    sop_entry = accept & s_sop;
    pix_write = sop_entry | (accept & (state == ACTIVE));
    pos_col   = sop_entry ? '0 : col;
    pos_row   = sop_entry ? '0 : row;
    at_last   = (pos_col == COL_W'(H_PIXELS - 1)) && (pos_row == ROW_W'(V_LINES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_SOP;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (pix_write) begin
      if (s_eop)        state_nxt = WAIT_SOP;
      else if (at_last) state_nxt = FLUSH;
      else              state_nxt = ACTIVE;
    end else if (accept && (state == FLUSH) && s_eop) begin
      state_nxt = WAIT_SOP;
    end
  end

  always_comb begin
    col_nxt  = col;
    row_nxt  = row;
    err_nxt  = pix_write & ((sop_entry & (state == ACTIVE)) | (at_last ^ s_eop));
    done_nxt = pix_write & at_last & s_eop & ~err_nxt;
    addr_nxt = ADDR_W'(pos_row) * ADDR_W'(H_PIXELS) + ADDR_W'(pos_col);
    data_nxt = {s_data[DATA_W-1 -: PK_W], s_data[2*CH_W-1 -: PK_W], s_data[CH_W-1 -: PK_W]};
    if (pix_write) begin
      if (state_nxt == ACTIVE) begin
        if (pos_col == COL_W'(H_PIXELS - 1)) begin
          col_nxt = '0;
          row_nxt = pos_row + 1'b1;
        end else begin
          col_nxt = pos_col + 1'b1;
          row_nxt = pos_row;
        end
      end else begin
        col_nxt = '0;
        row_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready    <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      s_ready    <= ~hold;
      wr_en      <= pix_write;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
      if (pix_write) begin
        wr_addr <= addr_nxt;
        wr_data <= data_nxt;
      end
    end
  end

  assign busy = (state == ACTIVE);

`ifdef PIXEL_FB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (done_nxt && (frame_count != 16'hFFFF)) frame_count <= frame_count + 16'd1;
      if (err_nxt && (err_count != 16'hFFFF))    err_count   <= err_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_stream_fb_writer.sv
// Randomised directed bench for pixel_stream_fb_writer on a reduced 16x6 frame,
// compared against a linear-pixel-index reference model.
`default_nettype none

module tb_pixel_stream_fb_writer;

  localparam int H  = 16;
  localparam int V  = 6;
  localparam int N  = H * V;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [29:0]   s_data;
  logic          s_valid, s_ready, s_sop, s_eop, hold;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          wr_en, frame_done, frame_err, busy;
`ifdef PIXEL_FB_STATS_EN
  logic [15:0]   frame_count, err_count;
`endif

  always #5 clk = ~clk;

  pixel_stream_fb_writer #(
    .H_PIXELS(H), .V_LINES(V), .DATA_W(30), .ADDR_W(AW), .PIX_W(12)
  ) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_sop(s_sop), .s_eop(s_eop), .hold(hold), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
`ifdef PIXEL_FB_STATS_EN
    , .frame_count(frame_count), .err_count(err_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = waiting for sop, 1 = inside a frame, 2 = discarding to eop.
  int mode = 0;
  int idx  = 0;
  bit rdy  = 0;
  int m_frames = 0;
  int m_errs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pack(input logic [29:0] d);
    return {d[29:26], d[19:16], d[9:6]};
  endfunction

  task automatic beat(input bit v, input bit sop, input bit eop, input logic [29:0] d, input bit h);
    bit acc, e_we, e_done, e_err, write_pix;
    int pos;
    s_valid = v; s_sop = sop; s_eop = eop; s_data = d; hold = h;
    acc = v && rdy;
    e_we = 0; e_done = 0; e_err = 0; write_pix = 0; pos = 0;
    if (acc) begin
      if (sop) begin
        e_err = (mode == 1);
        pos = 0;
        write_pix = 1;
      end else if (mode == 1) begin
        pos = idx;
        write_pix = 1;
      end else if (mode == 2 && eop) begin
        mode = 0;
      end
    end
    if (write_pix) begin
      e_we = 1;
      if (pos == N - 1) begin
        if (!eop) e_err = 1;
        else if (!e_err) e_done = 1;
        mode = eop ? 0 : 2;
      end else if (eop) begin
        e_err = 1;
        mode = 0;
      end else begin
        mode = 1;
        idx = pos + 1;
      end
    end
    if (e_done) m_frames++;
    if (e_err) m_errs++;
    rdy = !h;
    @(posedge clk); #1;
    chk("s_ready", s_ready, !h);
    chk("wr_en", wr_en, e_we);
    if (e_we) begin
      chk("wr_addr", wr_addr, pos);
      chk("wr_data", wr_data, pack(d));
    end
    chk("frame_done", frame_done, e_done);
    chk("frame_err", frame_err, e_err);
    chk("busy", busy, mode == 1);
`ifdef PIXEL_FB_STATS_EN
    chk("frame_count", frame_count, m_frames);
    chk("err_count", err_count, m_errs);
`endif
  endtask

  task automatic do_reset();
    reset = 1; s_valid = 1; s_sop = 0; s_eop = 0; hold = 0; s_data = $urandom;
    @(posedge clk); #1;
    mode = 0; idx = 0; rdy = 0; m_frames = 0; m_errs = 0;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
  endtask

  // Send `count` accepted beats; sop/eop mark beat numbers (-1 = none).
  task automatic send_beats(input int count, input int sop_i, input int eop_i,
                            input bit rnd_hold, input logic [29:0] fixed);
    int k = 0;
    int cyc = 0;
    bit v, h;
    while (k < count && cyc < count * 20 + 100) begin
      v = ($urandom_range(3) != 0);
      h = rnd_hold && ($urandom_range(7) == 0);
      if (v && rdy) begin
        beat(1, k == sop_i, k == eop_i, (fixed !== 'x) ? fixed : 30'($urandom), h);
        k++;
      end else begin
        beat(v, v ? (k == sop_i) : 1'($urandom), v ? (k == eop_i) : 1'($urandom),
             30'($urandom), h);
      end
      cyc++;
    end
    chk("beat_budget", k, count);
  endtask

  initial begin
    int rem;
    reset = 1; s_valid = 0; s_sop = 0; s_eop = 0; hold = 0; s_data = '0;
    do_reset();
    beat(0, 0, 0, 30'd0, 0);

    // 1: well-formed frame of constant colour
    send_beats(N, 0, N - 1, 0, 30'h3FF_003FF);
    // 2: stray beats before sop
    send_beats(10, -1, -1, 0, 'x);
    send_beats(N, 0, N - 1, 0, 'x);
    // 3: early eop
    send_beats(50, 0, 49, 0, 'x);
    send_beats(N, 0, N - 1, 1, 'x);
    // 4: sop mid-frame
    send_beats(60, 0, -1, 0, 'x);
    send_beats(N, 0, N - 1, 0, 'x);
    // 5: hold at pixel 17
    send_beats(17, 0, -1, 0, 'x);
    for (int i = 0; i < 20; i++) beat(1, 0, 0, 30'($urandom), 1);
    rem = N - idx;
    send_beats(rem, -1, rem - 1, 0, 'x);
    // 6: missing eop, then flushed beats
    send_beats(N, 0, -1, 0, 'x);
    send_beats(5, -1, 4, 0, 'x);
    send_beats(N, 0, N - 1, 1, 'x);
    // 7: reset mid-frame
    send_beats(40, 0, -1, 0, 'x);
    do_reset();
    send_beats(N, 0, N - 1, 0, 'x);
    // sop+eop together, and flush exit via sop
    send_beats(1, 0, 0, 0, 'x);
    send_beats(N, 0, -1, 0, 'x);
    send_beats(3, -1, -1, 0, 'x);
    send_beats(N, 0, N - 1, 1, 'x);
`ifdef PIXEL_FB_STATS_EN
    // 8: counters after one good frame and one early-eop frame
    do_reset();
    send_beats(N, 0, N - 1, 0, 'x);
    send_beats(50, 0, 49, 0, 'x);
    chk("stats_frames", frame_count, 16'd1);
    chk("stats_errs", err_count, 16'd1);
`endif
    beat(0, 0, 0, 30'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
